// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_LUI  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_NOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_core.sv
// Multiply/divide unit: result computed at start, held in a pending register,
// and committed to HI/LO after a fixed latency counted by a down-counter.
//   state   | meaning
//   MD_IDLE | accepts start; MTHI/MTLO write directly; 1-cycle ops commit at once
//   MD_BUSY | cnt counts down; pending result commits on the edge cnt reaches 1
module md_core #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  import alu_pkg::*;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 2);
  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  md_state_e state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, lat;
  logic [2*WIDTH-1:0] pend, pend_nx, res, prod_s, prod_u;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [WIDTH-1:0] mag_a, mag_b, dvs_s, dvs_u, uq_s, ur_s, quo_s, rem_s, quo_u, rem_u;
  logic div_zero, is_arith;

  // Signed division runs on magnitudes so most-negative / -1 wraps naturally.
  always_comb begin
    prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    div_zero = (b == '0);
    mag_a    = a[WIDTH-1] ? -a : a;
    mag_b    = b[WIDTH-1] ? -b : b;
    dvs_s    = div_zero ? ONE : mag_b;
    dvs_u    = div_zero ? ONE : b;
    uq_s     = mag_a / dvs_s;
    ur_s     = mag_a % dvs_s;
    quo_s    = (a[WIDTH-1] ^ b[WIDTH-1]) ? -uq_s : uq_s;
    rem_s    = a[WIDTH-1] ? -ur_s : ur_s;
    quo_u    = a / dvs_u;
    rem_u    = a % dvs_u;
    if (div_zero) begin
      quo_s = '1;
      rem_s = a;
      quo_u = '1;
      rem_u = a;
    end
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   res = {rem_s, quo_s};
      default:  res = {rem_u, quo_u};
    endcase
    lat      = (op == MD_MULT || op == MD_MULTU) ? MULT_LAT : DIV_LAT;
    is_arith = (op <= MD_DIVU);
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    hi_nx    = hi;
    lo_nx    = lo;
    case (state)
      MD_IDLE: begin
        if (start) begin
          if (is_arith) begin
            if (lat == CW'(1)) begin
              {hi_nx, lo_nx} = res;
            end else begin
              pend_nx  = res;
              cnt_nx   = lat;
              state_nx = MD_BUSY;
            end
          end else if (op == MD_MTHI) begin
            hi_nx = a;
          end else if (op == MD_MTLO) begin
            lo_nx = a;
          end
        end
      end
      default: begin
        cnt_nx = cnt - CW'(1);
        if (cnt == CW'(2)) begin
          {hi_nx, lo_nx} = pend;
          state_nx       = MD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
    end
  end

  assign busy = (state == MD_BUSY);

endmodule

// File: rtl/alu_md.sv
// EX-stage datapath: zero-latency integer ALU plus the multi-cycle mul/div unit.
module alu_md #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       Op,
  output logic [WIDTH-1:0] AO,
  output logic             Zero,
  output logic             Ovf,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             stall
);
  import alu_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff;

  assign shamt = A[SHW-1:0];
  assign sum   = A + B;
  assign diff  = A - B;
  assign Zero  = (A == B);

  always_comb begin
    AO  = A & B;
    Ovf = 1'b0;
    case (Op)
      ALU_OR:   AO = A | B;
      ALU_ADD: begin
        AO  = sum;
        Ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        AO  = diff;
        Ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_LUI:  AO = B << (WIDTH / 2);
      ALU_XOR:  AO = A ^ B;
      ALU_NOR:  AO = ~(A | B);
      ALU_SLT:  AO = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: AO = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SLL:  AO = B << shamt;
      ALU_SRL:  AO = B >> shamt;
      ALU_SRA:  AO = $signed(B) >>> shamt;
      default:  AO = A & B;
    endcase
  end

  md_core #(
    .WIDTH      (WIDTH),
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_core (
    .clk  (clk),
    .reset(reset),
    .a    (A),
    .b    (B),
    .start(md_start),
    .op   (md_op),
    .hi   (HI),
    .lo   (LO),
    .busy (busy)
  );

  // Stall also covers the start cycle so the hazard unit holds the next instruction.
  assign stall = busy | (md_start & (md_op <= MD_DIVU));

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: ALU vectors, mul/div latency, ignore-while-busy,
// mid-operation reset, and a 16-bit single-cycle-multiply instance.
module tb_alu_md;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b, ao, hi, lo;
  logic [3:0]  op;
  logic        zero, ovf, md_start, busy, stall;
  logic [2:0]  md_op;
  logic [15:0] a16, b16, ao16, hi16, lo16;
  logic [3:0]  op16;
  logic        zero16, ovf16, md_start16, busy16, stall16;
  logic [2:0]  md_op16;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .Op(op), .AO(ao), .Zero(zero), .Ovf(ovf),
    .md_start(md_start), .md_op(md_op), .HI(hi), .LO(lo), .busy(busy), .stall(stall)
  );

  alu_md #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .Op(op16), .AO(ao16), .Zero(zero16),
    .Ovf(ovf16), .md_start(md_start16), .md_op(md_op16), .HI(hi16), .LO(lo16),
    .busy(busy16), .stall(stall16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu(input string tag, input logic [3:0] o, input logic [31:0] x, y,
                     input logic [31:0] exp_ao, input logic exp_z, exp_ovf);
    op = o; a = x; b = y;
    #1;
    chk({tag, "_ao"}, ao, exp_ao);
    chk({tag, "_zero"}, zero, exp_z);
    chk({tag, "_ovf"}, ovf, exp_ovf);
  endtask

  // Called at a negedge; start is sampled at the next posedge, result lands n-1 edges later.
  task automatic md_run(input string tag, input logic [2:0] o, input logic [31:0] x, y,
                        input int n, input logic [31:0] exp_hi, exp_lo);
    md_op = o; a = x; b = y; md_start = 1'b1;
    #1;
    chk({tag, "_stall_start"}, stall, 1'b1);
    @(negedge clk);
    md_start = 1'b0;
    for (int i = 0; i < n - 1; i++) begin
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_stall"}, stall, 1'b1);
      @(negedge clk);
    end
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b0; a = '0; b = '0; op = ALU_AND; md_start = 1'b0; md_op = MD_MULT;
    a16 = '0; b16 = '0; op16 = ALU_AND; md_start16 = 1'b0; md_op16 = MD_MULT;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall, 1'b0);
    alu("add_in_reset", ALU_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    alu("add_ovf",  ALU_ADD,  32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
    alu("sub_zero", ALU_SUB,  32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
    alu("sub_ovf",  ALU_SUB,  32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1);
    alu("add_wrap", ALU_ADD,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
    alu("sra",      ALU_SRA,  32'd4, 32'h80000000, 32'hF8000000, 1'b0, 1'b0);
    alu("srl",      ALU_SRL,  32'd4, 32'h80000000, 32'h08000000, 1'b0, 1'b0);
    alu("sll",      ALU_SLL,  32'h24, 32'h1, 32'h10, 1'b0, 1'b0);
    alu("slt",      ALU_SLT,  32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    alu("sltu",     ALU_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
    alu("lui",      ALU_LUI,  32'h0, 32'h1234, 32'h12340000, 1'b0, 1'b0);
    alu("nor",      ALU_NOR,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0);
    alu("xor",      ALU_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0);
    alu("or",       ALU_OR,   32'h1, 32'h2, 32'h3, 1'b0, 1'b0);
    alu("and_eq",   ALU_AND,  32'hAA, 32'hAA, 32'hAA, 1'b1, 1'b0);
    alu("op13",     4'd13,    32'hF0, 32'h3C, 32'h30, 1'b0, 1'b0);
    @(negedge clk);

    md_run("mult",   MD_MULT,  32'hFFFFFFFD, 32'd7, 5, 32'hFFFFFFFF, 32'hFFFFFFEB);
    md_run("multu",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001);

    md_op = 3'd6; a = 32'h5555; md_start = 1'b1;
    #1 chk("op6_stall", stall, 1'b0);
    @(negedge clk);
    md_start = 1'b0;
    chk("op6_busy", busy, 1'b0);
    chk("op6_hi", hi, 32'hFFFFFFFE);
    chk("op6_lo", lo, 32'h00000001);

    md_run("div",    MD_DIV,  32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    md_run("divu0",  MD_DIVU, 32'd7, 32'd0, 10, 32'd7, 32'hFFFFFFFF);
    md_run("divmin", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    md_op = MD_DIV; a = 32'd100; b = 32'd7; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    md_op = MD_MTLO; a = 32'h1234; md_start = 1'b1;
    #1 chk("ign_mtlo_stall", stall, 1'b1);
    @(negedge clk);
    md_op = MD_MULT; a = 32'd3; b = 32'd3;
    #1 chk("ign_mult_stall", stall, 1'b1);
    @(negedge clk);
    md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("ign_busy", busy, 1'b1);
      @(negedge clk);
    end
    chk("ign_busy_done", busy, 1'b0);
    chk("ign_hi", hi, 32'd2);
    chk("ign_lo", lo, 32'd14);

    md_op = MD_MULT; a = 32'd5; b = 32'd6; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    chk("rmid_busy", busy, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rmid_hi", hi, 32'h0);
    chk("rmid_lo", lo, 32'h0);
    chk("rmid_busy0", busy, 1'b0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("rmid_late_hi", hi, 32'h0);
    chk("rmid_late_lo", lo, 32'h0);
    md_op = MD_MTHI; a = 32'hABCD; md_start = 1'b1;
    #1 chk("mthi_stall", stall, 1'b0);
    @(negedge clk);
    md_start = 1'b0;
    chk("mthi_hi", hi, 32'hABCD);
    chk("mthi_lo", lo, 32'h0);
    chk("mthi_busy", busy, 1'b0);
    md_op = MD_MTLO; a = 32'h5678; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    chk("mtlo_lo", lo, 32'h5678);
    chk("mtlo_hi", hi, 32'hABCD);

    op16 = ALU_LUI; a16 = 16'h0; b16 = 16'h00AB;
    #1 chk("w16_lui", ao16, 16'hAB00);
    op16 = ALU_ADD; a16 = 16'h7FFF; b16 = 16'h0001;
    #1 chk("w16_add", ao16, 16'h8000);
    chk("w16_ovf", ovf16, 1'b1);
    chk("w16_zero", zero16, 1'b0);
    @(negedge clk);
    md_op16 = MD_MULT; a16 = 16'hFFFD; b16 = 16'd7; md_start16 = 1'b1;
    #1 chk("w16_stall", stall16, 1'b1);
    chk("w16_busy_pre", busy16, 1'b0);
    @(negedge clk);
    md_start16 = 1'b0;
    chk("w16_busy", busy16, 1'b0);
    chk("w16_hi", hi16, 16'hFFFF);
    chk("w16_lo", lo16, 16'hFFEB);
    @(negedge clk);
    chk("w16_busy_after", busy16, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_md.md
Name: alu_md

Overview:
- Parametrised successor to the single-cycle datapath ALU, for the pipelined CPU's EX stage.
- Combinational integer ALU with a wider op set plus signed add/sub overflow detection.
- Adds a multi-cycle multiply/divide unit with HI/LO registers and a busy/stall handshake to the hazard unit.
- The ALU path stays zero-latency. Multiply and divide results appear in HI/LO after a fixed, parametrised latency.

Parameters:
- WIDTH, 32, datapath width; must be even and at least 8.
- MULT_CYCLES, 5, cycles from multiply start to HI/LO update; must be at least 1.
- DIV_CYCLES, 10, cycles from divide start to HI/LO update; must be at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low.
- A  in  WIDTH  operand A; also the shift amount for shift ops.
- B  in  WIDTH  operand B.
- Op  in  4  ALU operation select.
- AO  out  WIDTH  ALU result, combinational.
- Zero  out  1  A == B, combinational.
- Ovf  out  1  signed overflow; meaningful only for ADD and SUB.
- md_start  in  1  request a multiply/divide operation.
- md_op  in  3  multiply/divide operation select.
- HI  out  WIDTH  HI register.
- LO  out  WIDTH  LO register.
- busy  out  1  a multiply or divide is in flight.
- stall  out  1  busy | (md_start & md_op is MULT, MULTU, DIV or DIVU); drives the hazard unit.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- ALU Op encoding:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 3 SUB
  - 4 LUI: B << (WIDTH/2)
  - 5 XOR
  - 6 NOR
  - 7 SLT: signed, result zero-extended to 1 or 0
  - 8 SLTU
  - 9 SLL: B << A[log2(WIDTH)-1:0]
  - 10 SRL
  - 11 SRA: arithmetic
  - 12..15 yield AND
- ADD and SUB wrap modulo 2^WIDTH.
- Ovf = 1 iff the operands' sign bits make signed overflow possible and the result sign differs; Ovf = 0 for all other ops.
- md_op encoding: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are ignored.
- States are IDLE and BUSY, with down-counter cnt.
- In IDLE, md_start with op 0..3:
  - latch A, B and op;
  - compute the 2*WIDTH-bit product, or the quotient and remainder, into a pending register;
  - load cnt = MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
- busy is asserted from the cycle after start.
- In BUSY, cnt decrements each cycle. On the edge where cnt reaches 1:
  - HI/LO are written;
  - the state returns to IDLE;
  - busy drops in the same cycle HI/LO show the new value.
- Total: a start at edge t updates HI/LO at edge t+N, where N is the latency parameter.
- Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits. Signed for MULT, unsigned for MULTU.
- Divide: LO = quotient, HI = remainder. Signed DIV truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend. No exception is raised.
- Signed DIV of most-negative by -1: LO = most-negative, HI = 0.
- MTHI/MTLO when IDLE: write A into HI or LO at the next edge; single cycle; busy stays 0.
- Any md_start while busy (including MTHI/MTLO) is ignored. The hazard unit must hold the instruction via stall.
- Reset low at any edge, including mid-operation:
  - HI = LO = 0, busy = 0, state = IDLE, cnt = 0;
  - the pending result is discarded.
- AO, Zero and Ovf are combinational and unaffected by reset.

Decomposition:
- Package alu_pkg holds:
  - ALU op localparams (ALU_AND .. ALU_SRA);
  - MD op localparams (MD_MULT .. MD_MTLO);
  - state encoding (MD_IDLE, MD_BUSY).
- One natural sub-module, md_core: the latency counter, the pending result and the HI/LO registers.
- alu_md instantiates md_core and holds the combinational ALU.

Test Plan:
- ALU sweep, WIDTH=32:
  - A=0x7FFFFFFF, B=1, Op=ADD -> AO=0x80000000, Ovf=1.
  - A=5, B=5, Op=SUB -> AO=0, Zero=1, Ovf=0.
  - A=4, B=0x80000000, Op=SRA -> AO=0xF8000000.
  - A=0xFFFFFFFF, B=1, Op=SLT -> AO=1; Op=SLTU -> AO=0.
- MULT with A=-3, B=7, start at edge t -> busy=1 on edges t+1..t+4; at t+5 HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy=0. MULTU with A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV cases:
  - A=-7, B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU with A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
  - DIV with A=0x80000000, B=-1 -> LO=0x80000000, HI=0.
- Start a DIV, then at cycle 3 issue MTLO with A=0x1234 and a MULT -> both ignored. stall=1 throughout; final HI/LO come from the DIV only.
- Start a MULT, then drive reset low at cycle 2 -> next edge HI=LO=0, busy=0. After reset releases, MTHI with A=0xABCD -> HI=0xABCD one edge later.
- Repeat the MULT scenario with WIDTH=16, MULT_CYCLES=1 -> HI/LO update at t+1; busy is never observed high.
